// File: rtl/block_sequencer.sv
// Block sequencer: expands entropy-decoder symbols into exactly 64 explicit
// table-generator writes per block (zig-zag positions 0..63), with DC
// prediction, zero runs, ZRL, EOB fill and a sticky overflow flag.
module block_sequencer #(
   parameter int unsigned DC_PRED_EN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sym_valid,
   output logic       sym_ready,
   input  logic [3:0] sym_run,
   input  logic [7:0] sym_coef,
   input  logic       sym_eob,
   input  logic       sym_zrl,
   input  logic       pred_clr,
   output logic       tg_wr,
   output logic [3:0] tg_run,
   output logic [7:0] tg_coef,
   output logic       blk_done,
   output logic       err
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      ZEROS  = 2'd1,
      FILL   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] pos_q, pos_d;
   logic [4:0] zeros_left_q, zeros_left_d;
   logic       pend_q, pend_d;
   logic [7:0] pend_coef_q, pend_coef_d;
   logic [7:0] dc_pred_q, dc_pred_d;
   logic       tg_wr_q, tg_wr_d;
   logic [7:0] tg_coef_q, tg_coef_d;
   logic       last_q, last_d;
   logic       blk_done_q;
   logic       err_q, err_d;

   logic [7:0] dc_base;
   logic [7:0] dc_val;

   // DC value: predictor (cleared by a simultaneous pred_clr) plus differential
   always_comb begin
      dc_base = pred_clr ? '0 : dc_pred_q;
      dc_val  = (DC_PRED_EN != 0) ? dc_base + sym_coef : sym_coef;
   end

   // Next-state logic: symbol decode, zero/fill expansion, position tracking
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      zeros_left_d = zeros_left_q;
      pend_d       = pend_q;
      pend_coef_d  = pend_coef_q;
      dc_pred_d    = pred_clr ? '0 : dc_pred_q;
      err_d        = err_q;
      tg_wr_d      = 1'b0;
      tg_coef_d    = tg_coef_q;
      sym_ready    = (state_q == ACCEPT);

      case (state_q)
         ACCEPT: begin
            if (sym_valid) begin
               if (pos_q == 6'd0) begin
                  tg_wr_d   = 1'b1;
                  tg_coef_d = dc_val;
                  dc_pred_d = dc_val;
               end else if (sym_eob) begin
                  state_d = FILL;
               end else if (sym_zrl) begin
                  if ({1'b0, pos_q} + 7'd16 > 7'd64) begin
                     err_d   = 1'b1;
                     state_d = FILL;
                  end else begin
                     state_d      = ZEROS;
                     zeros_left_d = 5'd16;
                     pend_d       = 1'b0;
                  end
               end else if ({1'b0, pos_q} + {3'b000, sym_run} > 7'd63) begin
                  err_d   = 1'b1;
                  state_d = FILL;
               end else if (sym_run == 4'd0) begin
                  tg_wr_d   = 1'b1;
                  tg_coef_d = sym_coef;
               end else begin
                  state_d      = ZEROS;
                  zeros_left_d = {1'b0, sym_run};
                  pend_d       = 1'b1;
                  pend_coef_d  = sym_coef;
               end
            end
         end
         ZEROS: begin
            tg_wr_d = 1'b1;
            if (zeros_left_q != 5'd0) begin
               tg_coef_d    = '0;
               zeros_left_d = zeros_left_q - 5'd1;
               // A bare ZRL leaves on its last zero so no idle cycle is spent
               if (zeros_left_q == 5'd1 && !pend_q) begin
                  state_d = ACCEPT;
               end
            end else begin
               tg_coef_d = pend_coef_q;
               pend_d    = 1'b0;
               state_d   = ACCEPT;
            end
         end
         FILL: begin
            tg_wr_d   = 1'b1;
            tg_coef_d = '0;
         end
         default: begin
            state_d = ACCEPT;
         end
      endcase

      // Any write at position 63 closes the block, whatever state issued it
      if (tg_wr_d) begin
         pos_d = pos_q + 6'd1;
         if (pos_q == 6'd63) begin
            state_d      = ACCEPT;
            zeros_left_d = '0;
            pend_d       = 1'b0;
         end
      end
      last_d = tg_wr_d && (pos_q == 6'd63);
   end

   // State and registered outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ACCEPT;
         pos_q        <= '0;
         zeros_left_q <= '0;
         pend_q       <= 1'b0;
         pend_coef_q  <= '0;
         dc_pred_q    <= '0;
         tg_wr_q      <= 1'b0;
         tg_coef_q    <= '0;
         last_q       <= 1'b0;
         blk_done_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         zeros_left_q <= zeros_left_d;
         pend_q       <= pend_d;
         pend_coef_q  <= pend_coef_d;
         dc_pred_q    <= dc_pred_d;
         tg_wr_q      <= tg_wr_d;
         tg_coef_q    <= tg_coef_d;
         last_q       <= last_d;
         blk_done_q   <= last_q;
         err_q        <= err_d;
      end
   end

   assign tg_wr    = tg_wr_q;
   assign tg_run   = '0;
   assign tg_coef  = tg_coef_q;
   assign blk_done = blk_done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_block_sequencer.sv
// Self-checking bench for block_sequencer: scenario tasks drive symbols,
// a reference model pushes the expected write stream into a queue, and a
// monitor pops and compares every table-generator write and blk_done.
module tb_block_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sym_valid = 1'b0;
   logic       sym_ready;
   logic [3:0] sym_run = '0;
   logic [7:0] sym_coef = '0;
   logic       sym_eob = 1'b0;
   logic       sym_zrl = 1'b0;
   logic       pred_clr = 1'b0;
   logic       tg_wr;
   logic [3:0] tg_run;
   logic [7:0] tg_coef;
   logic       blk_done;
   logic       err;

   always #5 clk = ~clk;

   block_sequencer #(.DC_PRED_EN(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .sym_valid(sym_valid),
      .sym_ready(sym_ready),
      .sym_run  (sym_run),
      .sym_coef (sym_coef),
      .sym_eob  (sym_eob),
      .sym_zrl  (sym_zrl),
      .pred_clr (pred_clr),
      .tg_wr    (tg_wr),
      .tg_run   (tg_run),
      .tg_coef  (tg_coef),
      .blk_done (blk_done),
      .err      (err)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         mon_pos = 0;
   logic       exp_done = 1'b0;
   logic [7:0] last_coef = '0;
   int         wr_cnt = 0;
   int         done_cnt = 0;
   int         tb_pos = 0;
   logic [7:0] tb_pred = '0;

   function automatic void fill_model();
      for (int p = tb_pos; p < 64; p++) exp_q.push_back(8'h00);
      tb_pos = 0;
   endfunction

   // Compares every write against the scoreboard and blk_done timing
   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            mon_pos   = 0;
            exp_done  = 1'b0;
            last_coef = '0;
         end else begin
            checks++;
            if (blk_done !== exp_done) begin
               errors++;
               $display("FAIL blk_done pos=%0d got=%b required=%b", mon_pos, blk_done, exp_done);
            end
            if (blk_done === 1'b1) done_cnt++;
            if (tg_wr === 1'b1) begin
               wr_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write pos=%0d coef=%h required=no write", mon_pos, tg_coef);
               end else begin
                  e = exp_q.pop_front();
                  if (tg_coef !== e) begin
                     errors++;
                     $display("FAIL write_coef pos=%0d got=%h required=%h", mon_pos, tg_coef, e);
                  end
               end
               checks++;
               if (tg_run !== 4'd0) begin
                  errors++;
                  $display("FAIL tg_run pos=%0d got=%0d required=0", mon_pos, tg_run);
               end
               last_coef = tg_coef;
               exp_done  = (mon_pos == 63);
               mon_pos   = (mon_pos == 63) ? 0 : mon_pos + 1;
            end else begin
               exp_done = 1'b0;
               checks++;
               if (tg_coef !== last_coef) begin
                  errors++;
                  $display("FAIL coef_hold got=%h required=%h", tg_coef, last_coef);
               end
            end
         end
      end
   endtask

   task automatic send(input logic [3:0] run, input logic [7:0] coef, input logic eob,
                       input logic zrl, input logic clr, output int stalls);
      int n;
      logic [7:0] v;
      @(negedge clk);
      sym_run = run; sym_coef = coef; sym_eob = eob; sym_zrl = zrl;
      pred_clr = clr; sym_valid = 1'b1;
      n = 0;
      while (sym_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      stalls = n;
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL accept_timeout got=no ready required=ready within 500 cycles");
         sym_valid = 1'b0; pred_clr = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      sym_valid = 1'b0; pred_clr = 1'b0; sym_eob = 1'b0; sym_zrl = 1'b0;
      if (clr) tb_pred = '0;
      if (tb_pos == 0) begin
         v = tb_pred + coef;
         tb_pred = v;
         exp_q.push_back(v);
         tb_pos = 1;
      end else if (eob) begin
         fill_model();
      end else if (zrl) begin
         if (tb_pos + 16 > 64) fill_model();
         else begin
            repeat (16) exp_q.push_back(8'h00);
            tb_pos += 16;
            if (tb_pos == 64) tb_pos = 0;
         end
      end else if (tb_pos + int'(run) > 63) begin
         fill_model();
      end else begin
         repeat (int'(run)) exp_q.push_back(8'h00);
         exp_q.push_back(coef);
         tb_pos += int'(run) + 1;
         if (tb_pos == 64) tb_pos = 0;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got=%0d pending required=0", tag, exp_q.size());
      end
   endtask

   task automatic expect_first(input logic [7:0] val, input string tag);
      int n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (tg_wr === 1'b1) break;
         n++;
      end
      checks++;
      if (n >= 20 || tg_coef !== val) begin
         errors++;
         $display("FAIL %s got=%h required=%h", tag, tg_coef, val);
      end
   endtask

   task automatic count_ready_low(input int required, input string tag);
      int n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (sym_ready === 1'b1) break;
         n++;
      end
      checks++;
      if (n != required) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", tag, n, required);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1; sym_valid = 1'b0; pred_clr = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      tb_pos = 0; tb_pred = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (tg_wr !== 1'b0 || tg_coef !== 8'h00 || tg_run !== 4'd0 || blk_done !== 1'b0 ||
          err !== 1'b0 || sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got=wr%b coef%h run%h done%b err%b rdy%b required=wr0 coef00 run0 done0 err0 rdy1",
                  tg_wr, tg_coef, tg_run, blk_done, err, sym_ready);
      end
   endtask

   task automatic test_dc_eob();
      int s, w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      send(4'd0, 8'd5, 1'b0, 1'b0, 1'b0, s);
      expect_first(8'h05, "dc_first");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      count_ready_low(63, "fill_ready_low");
      drain("dc_eob");
      checks++;
      if (wr_cnt - w0 != 64) begin
         errors++; $display("FAIL eob_writes got=%0d required=64", wr_cnt - w0);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL eob_done got=%0d required=1", done_cnt - d0);
      end
   endtask

   task automatic test_dc_pred();
      int s;
      do_reset();
      send(4'd0, 8'd5, 1'b0, 1'b0, 1'b0, s);
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("pred_a");
      send(4'd0, 8'hFE, 1'b0, 1'b0, 1'b0, s);
      expect_first(8'h03, "dc_pred_sum");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("pred_b");
      @(posedge clk); #1 pred_clr = 1'b1;
      @(posedge clk); #1 pred_clr = 1'b0;
      tb_pred = '0;
      send(4'd0, 8'hFE, 1'b0, 1'b0, 1'b0, s);
      expect_first(8'hFE, "dc_after_clr");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("pred_c");
      // DC with clear in the same cycle and stray run/eob/zrl flags
      send(4'd9, 8'h07, 1'b1, 1'b1, 1'b1, s);
      expect_first(8'h07, "dc_clr_same_cycle");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("pred_d");
   endtask

   task automatic test_run_zeros();
      int s;
      send(4'd0, 8'd1, 1'b0, 1'b0, 1'b0, s);
      send(4'd3, 8'd7, 1'b0, 1'b0, 1'b0, s);
      count_ready_low(4, "run3_ready_low");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("run3");
   endtask

   task automatic test_back_to_back();
      int s, tot, w0, d0;
      do_reset();
      w0 = wr_cnt; d0 = done_cnt; tot = 0;
      send(4'd0, 8'd2, 1'b0, 1'b0, 1'b0, s);
      for (int i = 0; i < 63; i++) begin
         send(4'd0, 8'd1, 1'b0, 1'b0, 1'b0, s);
         tot += s;
      end
      drain("b2b");
      checks++;
      if (tot != 0) begin
         errors++; $display("FAIL b2b_stalls got=%0d required=0", tot);
      end
      checks++;
      if (wr_cnt - w0 != 64 || done_cnt - d0 != 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_block got=writes%0d done%0d err%b required=writes64 done1 err0",
                  wr_cnt - w0, done_cnt - d0, err);
      end
      send(4'd0, 8'd3, 1'b0, 1'b0, 1'b0, s);
      expect_first(8'h05, "b2b_next_dc");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("b2b_next");
   endtask

   task automatic test_zrl_boundary();
      int s, d0;
      d0 = done_cnt;
      send(4'd0, 8'd0, 1'b0, 1'b0, 1'b0, s);
      send(4'd0, 8'd0, 1'b0, 1'b1, 1'b0, s);
      send(4'd0, 8'd0, 1'b0, 1'b1, 1'b0, s);
      send(4'd14, 8'd2, 1'b0, 1'b0, 1'b0, s);
      send(4'd0, 8'd0, 1'b0, 1'b1, 1'b0, s);
      drain("zrl_edge");
      checks++;
      if (done_cnt - d0 != 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL zrl_edge got=done%0d err%b required=done1 err0", done_cnt - d0, err);
      end
   endtask

   task automatic test_overflow();
      int s, w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      send(4'd0, 8'h10, 1'b0, 1'b0, 1'b0, s);
      repeat (3) send(4'd0, 8'd0, 1'b0, 1'b1, 1'b0, s);
      send(4'd15, 8'd9, 1'b0, 1'b0, 1'b0, s);
      drain("ovf");
      checks++;
      if (err !== 1'b1 || wr_cnt - w0 != 64 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL ovf got=err%b writes%0d done%0d required=err1 writes64 done1",
                  err, wr_cnt - w0, done_cnt - d0);
      end
      send(4'd0, 8'd1, 1'b0, 1'b0, 1'b0, s);
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("ovf_sticky");
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_sticky got=%b required=1", err);
      end
   endtask

   task automatic test_reset_mid();
      int s, d0;
      send(4'd0, 8'h11, 1'b0, 1'b0, 1'b0, s);
      send(4'd0, 8'h33, 1'b0, 1'b0, 1'b0, s);
      send(4'd10, 8'd3, 1'b0, 1'b0, 1'b0, s);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      tb_pos = 0; tb_pred = '0;
      @(negedge clk);
      checks++;
      if (tg_wr !== 1'b0 || tg_coef !== 8'h00 || blk_done !== 1'b0 || err !== 1'b0 ||
          sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got=wr%b coef%h done%b err%b rdy%b required=wr0 coef00 done0 err0 rdy1",
                  tg_wr, tg_coef, blk_done, err, sym_ready);
      end
      d0 = done_cnt;
      send(4'd0, 8'd4, 1'b0, 1'b0, 1'b0, s);
      expect_first(8'h04, "mid_reset_dc");
      send(4'd0, 8'd0, 1'b1, 1'b0, 1'b0, s);
      drain("mid_reset");
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL mid_reset_done got=%0d required=1", done_cnt - d0);
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_dc_eob();
      test_dc_pred();
      test_run_zeros();
      test_back_to_back();
      test_zrl_boundary();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
